// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Font is active-high with segment a in bit 0.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF_AL = 7'h7F;
  localparam seg_t SEG_OFF_AH = 7'h00;

  localparam seg_t FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_font.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module sevenseg_font
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       glyph
);

  assign glyph = FONT[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex seven-segment driver with shadowed value/dp and registered outputs.
// Optional leading-zero blanking when SEVENSEG_LZ_BLANK_EN is defined.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
  localparam seg_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    tick_q, tick_d;
  logic                    wrap_q, wrap_d;

  logic                    tc;
  logic [3:0]              nib;
  logic                    dp_sel;
  logic [NUM_DIGITS-1:0]   onehot;
  seg_t                    glyph;
  seg_t                    seg_lit;

  always_comb begin
    tc     = (cnt_q == LAST_CNT);
    cnt_d  = tc ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tc) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    // wrap_q marks the cycle after the wrap edge, so the registered tick
    // lines up with the first registered digit-0 select.
    wrap_d = tc && (idx_q == LAST_IDX);
    val_d  = load ? value : val_q;
    dps_d  = load ? dp_in : dps_q;
  end

  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = val_q[4*i +: 4];
        dp_sel    = dps_q[i];
        onehot[i] = 1'b1;
      end
    end
  end

  sevenseg_font u_font (
    .nibble (nib),
    .glyph  (glyph)
  );

`ifdef SEVENSEG_LZ_BLANK_EN
  logic upper_zero;
  logic blank;

  // Walk from the top digit down; a digit blanks only while everything at or above it is empty.
  always_comb begin
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int unsigned j = 0; j + 1 < NUM_DIGITS; j++) begin
      upper_zero = upper_zero && (val_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0)
                              && !dps_q[NUM_DIGITS-1-j];
      if (idx_q == IW'(NUM_DIGITS - 1 - j)) blank = upper_zero;
    end
    seg_lit = blank ? '0 : glyph;
  end
`else
  assign seg_lit = glyph;
`endif

  always_comb begin
    seg_d  = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    dp_d   = (SEG_ACTIVE_LOW != 0) ? ~dp_sel : dp_sel;
    dig_d  = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
    tick_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dps_q  <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      dig_q  <= DIG_OFF;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      dps_q  <= dps_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign segments   = seg_q;
  assign dp         = dp_q;
  assign digit_en   = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan (4 digits, SCAN_DIV=4, active-low segments).
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  // Hand-inverted font (active-low view of the hex glyph table).
  localparam logic [6:0] FONT_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

  int          pos = 15;
  int          frames = 0;
  logic [15:0] sh_val = '0;
  logic [3:0]  sh_dp = '0;
  logic [6:0]  seg_at [4];
  logic        dp_at [4];
  int          ticks;

  sevenseg_scan #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .segments   (segments),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic chk);
    int          np;
    int          d;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        blank;
    logic        ld;
    logic [15:0] v;
    logic [3:0]  dv;
    np    = (pos + 1) % 16;
    d     = np / 4;
    v     = sh_val >> (4 * d);
    dv    = sh_dp >> d;
    blank = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
    blank = (d != 0) && (v == 16'h0) && (dv == 4'h0);
`endif
    e_seg = blank ? 7'h7F : FONT_AL[v[3:0]];
    e_dp  = ~dv[0];
    ld    = load;
    @(posedge clk);
    #1;
    pos = np;
    if (pos == 0) frames++;
    if (ld) begin
      sh_val = value;
      sh_dp  = dp_in;
    end
    if (frame_tick) ticks++;
    if (pos % 4 == 0) begin
      seg_at[pos/4] = segments;
      dp_at[pos/4]  = dp;
    end
    if (chk) begin
      check("seg", 32'(segments), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("digit_en", 32'(digit_en), 32'(4'b0001 << d));
      check("frame_tick", 32'(frame_tick), 32'((pos == 0) && (frames > 1)));
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("rst_seg", 32'(segments), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_dig", 32'(digit_en), 32'h0);
      check("rst_tick", 32'(frame_tick), 32'h0);
    end
    pos    = 15;
    frames = 0;
    sh_val = '0;
    sh_dp  = '0;
    reset  = 1'b0;
    load   = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step(1'b1);
    load  = 1'b0;
    value = 16'hDEAD;
    dp_in = 4'hF;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 16 && pos != target; i++) step(1'b1);
  endtask

  initial begin
    ticks = 0;
    do_reset(3);
    step(1'b1);
    check("first_dig", 32'(digit_en), 32'h1);
    check("first_seg", 32'(segments), 32'h40);

    run_to(15);
    load_word(16'h1A2F, 4'h0);
    run_to(15);
    run_to(0);
    run_to(15);
    check("f1_d0", 32'(seg_at[0]), 32'h0E);
    check("f1_d1", 32'(seg_at[1]), 32'h24);
    check("f1_d2", 32'(seg_at[2]), 32'h08);
    check("f1_d3", 32'(seg_at[3]), 32'h79);

    run_to(15);
    ticks = 0;
    for (int i = 0; i < 32; i++) step(1'b1);
    check("tick_count", 32'(ticks), 32'd2);

    run_to(8);
    load_word(16'h8888, 4'h0);
    step(1'b1);
    check("load_lat_seg", 32'(segments), 32'h00);
    step(1'b1);
    check("d2_last_cycle", 32'(digit_en), 32'h4);
    step(1'b1);
    check("d3_on_time", 32'(digit_en), 32'h8);

    run_to(14);
    load_word(16'h0050, 4'h0);
    run_to(15);
    run_to(14);
    step(1'b1);
`ifdef SEVENSEG_LZ_BLANK_EN
    check("lz_d3", 32'(seg_at[3]), 32'h7F);
    check("lz_d2", 32'(seg_at[2]), 32'h7F);
`else
    check("nolz_d3", 32'(seg_at[3]), 32'h40);
    check("nolz_d2", 32'(seg_at[2]), 32'h40);
`endif
    check("lz_d1", 32'(seg_at[1]), 32'h12);
    check("lz_d0", 32'(seg_at[0]), 32'h40);

    run_to(14);
    load_word(16'h0000, 4'b0100);
    run_to(15);
    run_to(14);
    step(1'b1);
`ifdef SEVENSEG_LZ_BLANK_EN
    check("lzdp_d3", 32'(seg_at[3]), 32'h7F);
`else
    check("nolzdp_d3", 32'(seg_at[3]), 32'h40);
`endif
    check("lzdp_d2", 32'(seg_at[2]), 32'h40);
    check("lzdp_d2_dp", 32'(dp_at[2]), 32'h0);
    check("lzdp_d1_dp", 32'(dp_at[1]), 32'h1);

    run_to(6);
    value = 16'hFFFF;
    dp_in = 4'hF;
    load  = 1'b1;
    do_reset(1);
    step(1'b1);
    check("post_rst_dig", 32'(digit_en), 32'h1);
    check("post_rst_seg", 32'(segments), 32'h40);
    check("post_rst_dp", 32'(dp), 32'h1);
    for (int i = 0; i < 16; i++) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Parametrised, time-multiplexed driver for a bank of hexadecimal seven-segment digits sharing one segment bus. It captures a packed multi-digit value on a load strobe and scans the digits one at a time at a programmable rate. Outputs are registered segment, decimal-point and digit-enable lines. It sits between the datapath and the board display pins and replaces a separate combinational decoder per digit.

## Interface
- NUM_DIGITS, 4: number of digits, 1..8.
- SCAN_DIV, 50000: clock cycles each digit is displayed, ≥1.
- SEG_ACTIVE_LOW, 1: 1 means segments and dp are driven low to light.
- DIG_ACTIVE_LOW, 0: 1 means digit enables are driven low to select.
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed nibbles; nibble 0 is the rightmost digit.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- load  in  1  capture value and dp_in into the shadow registers at this edge.
- segments  out  7  {g,f,e,d,c,b,a}; bit 0 is segment a.
- dp  out  1  decimal point of the selected digit.
- digit_en  out  NUM_DIGITS  one-hot digit select.
- frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Shadow registers hold the value and dp captured on `load`. Outside `load`, `value` and `dp_in` are ignored.
- A prescaler counts 0..SCAN_DIV-1. At its terminal count the digit index advances, wrapping from NUM_DIGITS-1 to 0.
- Font, active-high view (a=bit0): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→67, A→77, b→7C, C→58, d→5E, E→79, F→71. Invert these when SEG_ACTIVE_LOW=1.
- Output registers are loaded every cycle from the current index and the shadow contents:
  - segments = font of the indexed nibble.
  - dp = shadow dp bit of the indexed digit.
  - digit_en = one-hot of the index.
- Reset outputs:
  - segments: all unlit (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
  - dp: unlit.
  - digit_en: none selected.
  - frame_tick: 0.
  - Shadow registers, index and prescaler all 0.
- `load` is accepted at any cycle. It does not disturb the prescaler or the index.
- NUM_DIGITS=1: the index stays 0, and frame_tick pulses every SCAN_DIV cycles.
- SCAN_DIV=1: the index advances every cycle.

## Timing
- First edge with reset low: outputs show digit 0 of the shadow (all zeros). Before this edge nothing is selected.
- Each digit is selected for exactly SCAN_DIV consecutive cycles. A full frame is NUM_DIGITS*SCAN_DIV cycles.
- Load latency: shadow updates at the `load` edge. The segments change at the following edge, i.e. 1 cycle.
- frame_tick is high during the first cycle in which digit_en selects digit 0 after a wrap. It is not asserted on the first frame after reset.
- Reset asserted mid-scan: at that edge all outputs return to their reset values and the shadow clears. If `load` and reset are both high, reset wins.

## Configuration
- Macro: SEVENSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit i is blanked (segments unlit) when every nibble from NUM_DIGITS-1 down to i is zero and no dp bit at i or above is set.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the shadow contents, so it also takes effect with 1-cycle load latency.
- Undefined: every digit always shows its glyph. The blanking logic is absent.

## Structure
- Package `sevenseg_pkg` holds:
  - the 16-entry active-high font constant;
  - the `seg_t` typedef (logic [6:0]);
  - the unlit constants SEG_OFF_AL / SEG_OFF_AH.
- Sub-module `sevenseg_font`: combinational nibble→`seg_t` lookup from the package, active-high. Instantiated once on the muxed nibble. Polarity inversion happens in `sevenseg_scan`.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0 unless stated.
- Reset held 3 cycles → segments=7'h7F, dp=1, digit_en=4'b0000. First edge after release → digit_en=4'b0001, segments=7'h40.
- load value=16'h1A2F, dp_in=0 → over one frame, digit_en follows 0001 (×4 cycles), 0010, 0100, 1000 with segments 7'h0E, 7'h24, 7'h08, 7'h79.
- Frame wrap → frame_tick high for exactly one cycle every 16 cycles, coincident with digit_en=4'b0001.
- load 16'h8888 in the second cycle of digit 2 → next cycle segments=7'h00. Digit 2 still ends on schedule (scan phase unchanged).
- With SEVENSEG_LZ_BLANK_EN: load 16'h0050, dp_in=0 → digits 3 and 2 show 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40. Load 16'h0000 with dp_in=4'b0100 → digit 2 shows 7'h40 with dp=0, digit 3 blank.
- Reset asserted together with load mid-frame → next cycle all outputs at reset values and the shadow is zero (digit 0 shows 7'h40 after release).
